// File: rtl/request_unit_mp.sv
// Multi-port CPU request unit: latches imem/dmem requests until hit,
// with per-port wait counters, sticky timeouts and halt drain.
// Ports: CLK, RST (async high), ihit, iREN, dREN/dWEN/dhit[NPORTS], halt;
// imemren, dmemren/dmemwen/timeout[NPORTS], wait_cnt[NPORTS*CNTW],
// halted, req_count[32]. Define REQUEST_UNIT_STATS_EN to enable req_count.
module request_unit_mp #(
  parameter int NPORTS  = 2,
  parameter int CNTW    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic                   iREN,
  input  logic [NPORTS-1:0]      dREN,
  input  logic [NPORTS-1:0]      dWEN,
  input  logic [NPORTS-1:0]      dhit,
  input  logic                   halt,
  output logic                   imemren,
  output logic [NPORTS-1:0]      dmemren,
  output logic [NPORTS-1:0]      dmemwen,
  output logic [NPORTS-1:0]      timeout,
  output logic [NPORTS*CNTW-1:0] wait_cnt,
  output logic                   halted,
  output logic [31:0]            req_count
);

  typedef enum logic [1:0] {
    G_RUN,
    G_DRAIN,
    G_HALTED
  } gstate_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_RD,
    P_WR
  } pstate_t;

  localparam logic [CNTW-1:0] TO = CNTW'(TIMEOUT);

  gstate_t r_gstate;
  gstate_t w_gnext;

  pstate_t r_pstate [NPORTS];
  pstate_t w_pnext  [NPORTS];

  logic [CNTW-1:0]   r_cnt [NPORTS];
  logic [NPORTS-1:0] r_timeout;
  logic              r_imemren;

  logic [NPORTS-1:0] w_rd;
  logic [NPORTS-1:0] w_wr;
  logic [NPORTS-1:0] w_busy;
  logic              w_stop;

  // A halt seen in RUN already blocks new latches and drops reads,
  // so the drain takes effect in the same edge that samples halt.
  assign w_stop = (r_gstate != G_RUN) | halt;

  always_comb begin
    w_rd   = '0;
    w_wr   = '0;
    w_busy = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_rd[i]   = (r_pstate[i] == P_RD);
      w_wr[i]   = (r_pstate[i] == P_WR);
      w_busy[i] = w_rd[i] | w_wr[i];
    end
  end

  always_comb begin
    w_gnext = r_gstate;
    case (r_gstate)
      G_RUN:    if (halt) w_gnext = G_DRAIN;
      G_DRAIN:  if (!(|w_wr)) w_gnext = G_HALTED;
      G_HALTED: w_gnext = G_HALTED;
      default:  w_gnext = G_RUN;
    endcase
  end

  // dhit wins over ihit: a retiring port goes idle and cannot
  // re-latch in that same cycle.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      w_pnext[i] = r_pstate[i];
      case (r_pstate[i])
        P_IDLE: begin
          if (!w_stop && ihit && dWEN[i])
            w_pnext[i] = P_WR;
          else if (!w_stop && ihit && dREN[i])
            w_pnext[i] = P_RD;
        end
        P_RD: begin
          if (dhit[i] || w_stop)
            w_pnext[i] = P_IDLE;
        end
        P_WR: begin
          if (dhit[i])
            w_pnext[i] = P_IDLE;
        end
        default: w_pnext[i] = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gstate  <= G_RUN;
      r_imemren <= 1'b1;
    end else begin
      r_gstate  <= w_gnext;
      r_imemren <= (w_gnext == G_RUN) & iREN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NPORTS; i++) begin
        r_pstate[i] <= P_IDLE;
        r_cnt[i]    <= '0;
      end
      r_timeout <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        r_pstate[i] <= w_pnext[i];
        if (!w_busy[i] && (w_pnext[i] != P_IDLE))
          r_cnt[i] <= '0;
        else if (w_busy[i] && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + 1'b1;
        if (w_busy[i] && (r_cnt[i] == TO))
          r_timeout[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt = '0;
    for (int i = 0; i < NPORTS; i++)
      wait_cnt[i*CNTW +: CNTW] = r_cnt[i];
  end

  assign imemren = r_imemren;
  assign dmemren = w_rd;
  assign dmemwen = w_wr;
  assign timeout = r_timeout;
  assign halted  = (r_gstate == G_HALTED);

`ifdef REQUEST_UNIT_STATS_EN
  logic [NPORTS-1:0] w_done;
  logic [31:0]       w_ret;
  logic [31:0]       r_req_count;

  assign w_done = dhit & w_busy;

  always_comb begin
    w_ret = '0;
    for (int i = 0; i < NPORTS; i++)
      w_ret = w_ret + 32'(w_done[i]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_req_count <= '0;
    else
      r_req_count <= r_req_count + w_ret;
  end

  assign req_count = r_req_count;
`else
  assign req_count = '0;
`endif

endmodule

// File: tb/tb_request_unit_mp.sv
// Directed bench for request_unit_mp (NPORTS=2, CNTW=8, TIMEOUT=5).
// Expected values are hand-derived per step.
module tb_request_unit_mp;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic        iREN;
  logic [1:0]  dREN;
  logic [1:0]  dWEN;
  logic [1:0]  dhit;
  logic        halt;
  logic        imemren;
  logic [1:0]  dmemren;
  logic [1:0]  dmemwen;
  logic [1:0]  timeout;
  logic [15:0] wait_cnt;
  logic        halted;
  logic [31:0] req_count;

  int checks   = 0;
  int failures = 0;

`ifdef REQUEST_UNIT_STATS_EN
  localparam logic [31:0] EXP_CNT = 32'd5;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif

  request_unit_mp #(
    .NPORTS(2),
    .CNTW(8),
    .TIMEOUT(5)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ihit(ihit),
    .iREN(iREN),
    .dREN(dREN),
    .dWEN(dWEN),
    .dhit(dhit),
    .halt(halt),
    .imemren(imemren),
    .dmemren(dmemren),
    .dmemwen(dmemwen),
    .timeout(timeout),
    .wait_cnt(wait_cnt),
    .halted(halted),
    .req_count(req_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST  = 1'b1;
    ihit = 1'b0;
    iREN = 1'b1;
    dREN = 2'b00;
    dWEN = 2'b00;
    dhit = 2'b00;
    halt = 1'b0;
    step();
    step();
    chk("rst_imemren", 32'(imemren), 32'd1);
    chk("rst_dmemren", 32'(dmemren), 32'd0);
    chk("rst_dmemwen", 32'(dmemwen), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_waitcnt", 32'(wait_cnt), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_reqcnt", req_count, 32'd0);
    RST = 1'b0;

    iREN = 1'b0;
    step();
    chk("imem_follow0", 32'(imemren), 32'd0);
    iREN = 1'b1;
    step();
    chk("imem_follow1", 32'(imemren), 32'd1);

    ihit = 1'b1;
    dREN = 2'b01;
    step();
    chk("rd_latch", 32'(dmemren), 32'd1);
    ihit = 1'b0;
    dREN = 2'b00;
    step();
    step();
    chk("rd_wait2", 32'(wait_cnt[7:0]), 32'd2);
    chk("rd_hold", 32'(dmemren), 32'd1);
    dhit = 2'b01;
    step();
    dhit = 2'b00;
    chk("rd_done", 32'(dmemren), 32'd0);
    chk("rd_wait3", 32'(wait_cnt[7:0]), 32'd3);
    step();
    chk("rd_idle_hold", 32'(wait_cnt[7:0]), 32'd3);

    ihit = 1'b1;
    dREN = 2'b11;
    dWEN = 2'b10;
    step();
    chk("prio_wen", 32'(dmemwen), 32'd2);
    chk("prio_ren", 32'(dmemren), 32'd1);
    chk("prio_clr", 32'(wait_cnt), 32'd0);
    dREN = 2'b00;
    dWEN = 2'b10;
    dhit = 2'b10;
    step();
    chk("coll_wen", 32'(dmemwen), 32'd0);
    chk("coll_ren", 32'(dmemren), 32'd1);
    ihit = 1'b0;
    dWEN = 2'b00;
    dhit = 2'b01;
    step();
    dhit = 2'b00;
    chk("coll_idle_r", 32'(dmemren), 32'd0);
    chk("coll_idle_w", 32'(dmemwen), 32'd0);
    chk("coll_wait", 32'(wait_cnt), 32'h0102);

    ihit = 1'b1;
    dREN = 2'b01;
    dWEN = 2'b10;
    step();
    chk("dual_ren", 32'(dmemren), 32'd1);
    chk("dual_wen", 32'(dmemwen), 32'd2);
    ihit = 1'b0;
    dREN = 2'b00;
    dWEN = 2'b00;
    dhit = 2'b11;
    step();
    dhit = 2'b00;
    chk("dual_done", 32'({dmemwen, dmemren}), 32'd0);
    chk("dual_wait", 32'(wait_cnt), 32'h0101);
    chk("stats_cnt", req_count, EXP_CNT);
    chk("ign_timeout", 32'(timeout), 32'd0);

    dhit = 2'b01;
    step();
    dhit = 2'b00;
    chk("idle_dhit", 32'(dmemren), 32'd0);

    ihit = 1'b1;
    dREN = 2'b01;
    step();
    ihit = 1'b0;
    dREN = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 5)
        chk("to_before", 32'(timeout), 32'd0);
      if (k == 6)
        chk("to_set", 32'(timeout), 32'd1);
    end
    chk("to_wait10", 32'(wait_cnt[7:0]), 32'd10);
    chk("to_noabort", 32'(dmemren), 32'd1);
    dhit = 2'b01;
    step();
    dhit = 2'b00;
    chk("to_sticky", 32'(timeout), 32'd1);
    chk("to_done", 32'(dmemren), 32'd0);

    ihit = 1'b1;
    dREN = 2'b01;
    dWEN = 2'b10;
    step();
    ihit = 1'b0;
    dREN = 2'b00;
    dWEN = 2'b00;
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("drn_rdrop", 32'(dmemren), 32'd0);
    chk("drn_imem", 32'(imemren), 32'd0);
    chk("drn_whold", 32'(dmemwen), 32'd2);
    chk("drn_halted0", 32'(halted), 32'd0);
    step();
    step();
    step();
    chk("drn_whold3", 32'(dmemwen), 32'd2);
    chk("drn_halted1", 32'(halted), 32'd0);
    dhit = 2'b10;
    step();
    dhit = 2'b00;
    chk("drn_wdone", 32'(dmemwen), 32'd0);
    chk("drn_halted2", 32'(halted), 32'd0);
    step();
    chk("drn_halted", 32'(halted), 32'd1);
    ihit = 1'b1;
    dREN = 2'b01;
    step();
    ihit = 1'b0;
    dREN = 2'b00;
    chk("hlt_nolatch", 32'(dmemren), 32'd0);
    chk("hlt_imem", 32'(imemren), 32'd0);
    chk("hlt_stay", 32'(halted), 32'd1);

    RST = 1'b1;
    step();
    RST = 1'b0;
    ihit = 1'b1;
    dWEN = 2'b10;
    step();
    ihit = 1'b0;
    dWEN = 2'b00;
    chk("mid_wen", 32'(dmemwen), 32'd2);
    step();
    RST = 1'b1;
    #1;
    chk("arst_wen", 32'(dmemwen), 32'd0);
    chk("arst_ren", 32'(dmemren), 32'd0);
    chk("arst_wait", 32'(wait_cnt), 32'd0);
    chk("arst_to", 32'(timeout), 32'd0);
    chk("arst_imem", 32'(imemren), 32'd1);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_reqcnt", req_count, 32'd0);
    #2;
    RST = 1'b0;
    step();

    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("ih_drain", 32'(halted), 32'd0);
    step();
    chk("ih_halted", 32'(halted), 32'd1);
    step();
    step();
    chk("ih_sticky", 32'(halted), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/request_unit_mp.md
Name: request_unit_mp

Overview:
- Parametrised, multi-port successor to the single-channel CPU request unit.
- Sits between the datapath and the cache/memory interface.
- Latches instruction and data memory requests and holds them until the matching hit arrives.
- Adds per-port wait counters, a timeout flag, and an orderly halt drain: pending writes complete before the core reports halted.

Parameters:
- NPORTS, 2, number of independent data request ports (1..8)
- CNTW, 8, width of each per-port wait counter
- TIMEOUT, 200, wait-cycle count at which the timeout flag sets (must be < 2^CNTW)

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  asynchronous active-high reset
- ihit  input  1  instruction fetch completed; pipeline advances
- iREN  input  1  datapath wants instruction fetch
- dREN  input  NPORTS  per-port data read request from datapath
- dWEN  input  NPORTS  per-port data write request from datapath
- dhit  input  NPORTS  per-port data access completed
- halt  input  1  datapath halt request
- imemren  output  1  registered instruction read enable to memory
- dmemren  output  NPORTS  registered data read enable per port
- dmemwen  output  NPORTS  registered data write enable per port
- timeout  output  NPORTS  sticky per-port timeout flag
- wait_cnt  output  NPORTS*CNTW  packed per-port wait counters, port i at [i*CNTW +: CNTW]
- halted  output  1  sticky: halt accepted and all writes drained
- req_count  output  32  completed-transaction count (see Optional Feature)

Behaviour:
- Reset (async, RST=1): imemren=1, dmemren=0, dmemwen=0, timeout=0, wait_cnt=0, halted=0, req_count=0, global state RUN, every port IDLE.
- Per-port FSM with states IDLE, RD, WR:
  - IDLE, no halt pending: on ihit & dWEN[i] go to WR; else on ihit & dREN[i] go to RD. dWEN wins if both are high.
  - RD/WR: stay until dhit[i]=1, then go to IDLE the next cycle.
  - dhit[i] in IDLE: ignored, no state change.
  - dhit[i] and ihit in the same cycle while in RD/WR: dhit has priority. The port returns to IDLE and does not re-latch that cycle; a new request needs a later ihit.
- dmemren[i] = (state==RD), dmemwen[i] = (state==WR). Both are registered and never high together.
- Latency: request latched on the ihit edge, so the enable is visible the following cycle. Enable drops the cycle after dhit.
- wait_cnt[i]:
  - Clears to 0 on entry to RD/WR.
  - Increments each cycle while in RD/WR and saturates at 2^CNTW-1.
  - Holds its value in IDLE, for debug.
- timeout[i]: sets when wait_cnt[i]==TIMEOUT while busy. Sticky until RST. The request is not aborted.
- imemren, registered:
  - RUN: follows iREN.
  - DRAIN/HALTED: 0.
- Global FSM RUN, DRAIN, HALTED:
  - RUN to DRAIN: halt=1 sampled.
  - In DRAIN: no new latches. Ports in RD go to IDLE the next cycle (read dropped). Ports in WR hold until dhit.
  - DRAIN to HALTED: the cycle after no port is in WR. halted=1 from then on.
  - HALTED: terminal until RST. halt deassertion is ignored.
  - halt sampled while every port is IDLE: RUN, then DRAIN for one cycle, then HALTED, so halted rises 2 cycles after halt is sampled.
- RST mid-transaction: all enables drop immediately (async). No completion is recorded.

Optional Feature:
- Macro: REQUEST_UNIT_STATS_EN.
- Defined: req_count increments by the number of ports whose dhit retires an RD/WR in that cycle (0..NPORTS, summed). The counter wraps at 2^32. Dropped reads in DRAIN are not counted.
- Not defined: req_count is tied to 0 and no counter logic is synthesised.

Test Plan:
- Basic read, NPORTS=2: ihit=1 with dREN=2'b01 -> dmemren=01 next cycle. dhit=01 arrives 3 cycles later -> dmemren=00 next cycle, wait_cnt[0]=3.
- Read/write priority and collision: dREN=11, dWEN=10 with ihit -> dmemwen=10, dmemren=01. Next, dhit=10 and ihit with dWEN=10 in the same cycle -> port1 goes to IDLE, no re-latch.
- Timeout, TIMEOUT=5: latch port0 read, withhold dhit for 10 cycles -> timeout[0]=1 from cycle 6 after latch, dmemren[0] still 1, wait_cnt[0]=10.
- Halt drain: port0 in RD, port1 in WR, assert halt -> dmemren[0]=0 next cycle, imemren=0. dhit[1] after 4 cycles -> halted=1 the cycle after dmemwen[1] falls.
- Idle halt: all ports IDLE, halt pulse for 1 cycle -> halted=1 two cycles later and stays 1 after halt drops.
- Stats/reset, with REQUEST_UNIT_STATS_EN defined: 3 reads and 2 writes retired, including one cycle with dhit=11 -> req_count=5. Then RST pulse mid-write -> all outputs return to reset values, req_count=0.
